// File: rtl/fk_pkg.sv
// fk_pkg: fk phase encoding and shared helpers for the fk phase scheduler.
// Revision 1.0
`default_nettype none

package fk_pkg;

  localparam int FK_W = 3;

  localparam logic [FK_W-1:0] FK_IDLE    = 3'd0;
  localparam logic [FK_W-1:0] FK_S_TXID  = 3'd1;
  localparam logic [FK_W-1:0] FK_S_RXFHS = 3'd2;
  localparam logic [FK_W-1:0] FK_S_ACKFHS = 3'd3;
  localparam logic [FK_W-1:0] FK_CONN_S  = 3'd4;
  localparam logic [FK_W-1:0] FK_M_TXFHS = 3'd5;
  localparam logic [FK_W-1:0] FK_M_RXACK = 3'd6;
  localparam logic [FK_W-1:0] FK_CONN_M  = 3'd7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fk_resp_cnt.sv
// fk_resp_cnt: wrapping response counter with clear > load-to-1 > increment priority.
// Revision 1.0
`default_nettype none

module fk_resp_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         incr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(1);
    end else if (incr) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fk_phase_sched.sv
// fk_phase_sched: page / page-scan hop-kernel phase tracker with clkN1/clkE1 freeze counters.
// Revision 1.0
`default_nettype none

module fk_phase_sched
  import fk_pkg::*;
#(
  parameter int N_W       = 6,
  parameter int E_W       = 5,
  parameter int RESP_TO   = 8,
  parameter int MAX_RETRY = 4
) (
  input  logic            clk_6M,
  input  logic            rst,
  input  logic            fkset_p,
  input  logic            txbit_period,
  input  logic            rxbit_period,
  input  logic            scancase_fk_chg_p,
  input  logic            ps,
  input  logic            pagetmp,
  input  logic            mpr,
  input  logic            corre_threshold,
  input  logic            m_half_tslot_p,
  input  logic            m_tslot_p,
  input  logic            abort,
  input  logic            CLKN0,
  input  logic            CLKE0,
  input  logic            CLK0,
  input  logic            CLKE1,
  output logic [FK_W-1:0] fk_state,
  output logic            fk_chg_p,
  output logic            fk_chg_p_ff,
  output logic            fk_spr,
  output logic            fk_mpr,
  output logic [N_W-1:0]  counter_clkN1,
  output logic [E_W-1:0]  counter_clkE1,
  output logic            conn_done_p,
  output logic            resp_timeout_p
);

  localparam int CW = $clog2(max2(RESP_TO, MAX_RETRY) + 1);
  localparam logic [CW-1:0] MISS_LAST  = CW'(RESP_TO - 1);
  localparam logic [CW-1:0] RETRY_LAST = CW'(MAX_RETRY);

  logic [FK_W-1:0] state;
  logic [FK_W-1:0] state_nxt;
  logic [CW-1:0]   miss;
  logic [CW-1:0]   retry;
  logic            ack_seen;
  logic            chg;

  logic n1_load, n1_incr;
  logic miss_clr, miss_incr;
  logic retry_clr, retry_incr;
  logic ack_clr, ack_set;
  logic done_nxt, to_nxt;

  assign chg      = fkset_p & ~(txbit_period | rxbit_period);
  assign fk_chg_p = chg;
  assign fk_state = state;

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state <= FK_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    n1_load    = 1'b0;
    n1_incr    = 1'b0;
    miss_clr   = 1'b0;
    miss_incr  = 1'b0;
    retry_clr  = 1'b0;
    retry_incr = 1'b0;
    ack_clr    = 1'b0;
    ack_set    = 1'b0;
    done_nxt   = 1'b0;
    to_nxt     = 1'b0;
    if (abort) begin
      state_nxt = FK_IDLE;
      miss_clr  = 1'b1;
      retry_clr = 1'b1;
      ack_clr   = 1'b1;
    end else begin
      case (state)
        FK_IDLE: begin
          // Slave scan hit takes precedence over a master ID response.
          if (ps & corre_threshold & fkset_p) begin
            state_nxt = FK_S_TXID;
            n1_load   = 1'b1;
          end else if (pagetmp & chg) begin
            state_nxt = FK_M_TXFHS;
            retry_clr = 1'b1;
          end
        end
        FK_S_TXID: begin
          if (chg) begin
            state_nxt = FK_S_RXFHS;
            n1_incr   = 1'b1;
            miss_clr  = 1'b1;
          end
        end
        FK_S_RXFHS: begin
          if (chg & corre_threshold) begin
            state_nxt = FK_S_ACKFHS;
          end else if (chg & CLKN0) begin
            // The final missed slot gives up rather than advancing clkN1.
            if (miss == MISS_LAST) begin
              state_nxt = FK_IDLE;
              to_nxt    = 1'b1;
            end else begin
              n1_incr   = 1'b1;
              miss_incr = 1'b1;
            end
          end
        end
        FK_S_ACKFHS: begin
          if (chg & CLKN0) begin
            state_nxt = FK_CONN_S;
            n1_incr   = 1'b1;
          end
        end
        FK_CONN_S, FK_CONN_M: begin
          if (chg & CLK0) begin
            state_nxt = FK_IDLE;
            done_nxt  = 1'b1;
          end
        end
        FK_M_TXFHS: begin
          if (chg) begin
            state_nxt = FK_M_RXACK;
            ack_clr   = 1'b1;
          end
        end
        FK_M_RXACK: begin
          ack_set = corre_threshold;
          if (m_half_tslot_p & (ack_seen | corre_threshold)) begin
            state_nxt = FK_CONN_M;
          end else if (chg & CLKE0 & ~ack_seen) begin
            if (retry == RETRY_LAST) begin
              state_nxt = FK_IDLE;
              to_nxt    = 1'b1;
            end else begin
              state_nxt  = FK_M_TXFHS;
              retry_incr = 1'b1;
            end
          end
        end
        default: state_nxt = FK_IDLE;
      endcase
    end
  end

  always_comb begin
    fk_spr = (state == FK_S_TXID) || (state == FK_S_RXFHS) || (state == FK_S_ACKFHS);
    fk_mpr = (state == FK_M_TXFHS) || (state == FK_M_RXACK);
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      miss           <= '0;
      retry          <= '0;
      ack_seen       <= 1'b0;
      fk_chg_p_ff    <= 1'b0;
      conn_done_p    <= 1'b0;
      resp_timeout_p <= 1'b0;
    end else begin
      if (miss_clr) begin
        miss <= '0;
      end else if (miss_incr) begin
        miss <= miss + CW'(1);
      end
      if (retry_clr) begin
        retry <= '0;
      end else if (retry_incr) begin
        retry <= retry + CW'(1);
      end
      if (ack_clr) begin
        ack_seen <= 1'b0;
      end else if (ack_set) begin
        ack_seen <= 1'b1;
      end
      fk_chg_p_ff    <= chg | scancase_fk_chg_p;
      conn_done_p    <= done_nxt;
      resp_timeout_p <= to_nxt;
    end
  end

  fk_resp_cnt #(.W(N_W)) u_cnt_clkn1 (
    .clk  (clk_6M),
    .rst  (rst),
    .clr  (1'b0),
    .load (n1_load),
    .incr (n1_incr),
    .cnt  (counter_clkN1)
  );

  // clkE1 follows master page response only, regardless of fk phase.
  fk_resp_cnt #(.W(E_W)) u_cnt_clke1 (
    .clk  (clk_6M),
    .rst  (rst),
    .clr  (~mpr),
    .load (1'b0),
    .incr (CLKE1 & m_tslot_p),
    .cnt  (counter_clkE1)
  );

endmodule

`default_nettype wire
